// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/PC widths and instruction field slices.
// Used by the fetch stage and by the IF/ID buffer, so both decode fields identically.
// Combinational only; no handshakes.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int PC_W   = 32;

    // Instruction field slices (bit positions within the 32-bit word)
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 10;

    function automatic logic [OPC_HI-OPC_LO:0] get_opcode(input logic [WORD_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [RD_HI-RD_LO:0] get_rd(input logic [WORD_W-1:0] word);
        return word[RD_HI:RD_LO];
    endfunction

    function automatic logic [RS_HI-RS_LO:0] get_rs(input logic [WORD_W-1:0] word);
        return word[RS_HI:RS_LO];
    endfunction

    function automatic logic [RT_HI-RT_LO:0] get_rt(input logic [WORD_W-1:0] word);
        return word[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO holding {pc, instr} pairs for the fetch stage.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
// Ports: clock, push/push_dat (write), pop (advance head), flush (empty in one edge),
//        count (occupied entries), head (oldest entry, zero when empty).
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                      clock,
    input  logic                      push,
    input  logic [W-1:0]              push_dat,
    input  logic                      pop,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count,
    output logic [W-1:0]              head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Pointers wrap naturally (DEPTH is a power of two); r_count tells full from empty.
    always_ff @(posedge clock) begin
        if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    assign count = r_count;
    assign head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage; owns the fetch PC, issues 1-cycle-latency word reads,
//          queues responses and hands them to decode with valid/ready.
// Latency: first instruction reaches decode 2 cycles after reset release or a redirect.
// Backpressure: id_ready low fills the queue; issue stops once queue + in-flight reaches DEPTH.
// Ports: clock/reset (sync, active-high); imem_req/imem_addr/imem_rdata to instruction memory;
//        redirect_valid/redirect_addr from writeback; id_ready/instr_valid/instr/instr_pc to
//        decode; queue_count occupancy.
// Build option FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_flushed/perf_stall outputs.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] PC_RESET = 32'd0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [WORD_W-1:0]       imem_rdata,
    input  logic                    redirect_valid,
    input  logic [PC_W-1:0]         redirect_addr,
    input  logic                    id_ready,
    output logic                    instr_valid,
    output logic [WORD_W-1:0]       instr,
    output logic [PC_W-1:0]         instr_pc,
    output logic [$clog2(DEPTH):0]  queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_flushed,
    output logic [31:0]             perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]         r_fetch_pc;
    logic                    r_inflight;
    logic [PC_W-1:0]         r_inflight_pc;

    logic [CNT_W-1:0]        w_fifo_count;
    logic [PC_W+WORD_W-1:0]  w_fifo_head;
    logic [CNT_W-1:0]        w_occ;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic                    w_head_vld;

    // Credits: queued entries plus the outstanding request never exceed DEPTH,
    // so a response always has a slot waiting for it.
    assign w_occ   = w_fifo_count + {{(CNT_W-1){1'b0}}, r_inflight};
    assign w_issue = !reset && !redirect_valid && (w_occ < CNT_W'(DEPTH));

    assign w_flush    = reset || redirect_valid;
    assign w_push     = r_inflight && !w_flush;
    assign w_head_vld = !reset && !redirect_valid && (w_fifo_count != '0);
    assign w_pop      = w_head_vld && id_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= PC_RESET;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            // Any response arriving next cycle belongs to the wrong path: drop it.
            r_fetch_pc <= redirect_addr;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + WORD_W)
    ) u_fifo (
        .clock    (clock),
        .push     (w_push),
        .push_dat ({r_inflight_pc, imem_rdata}),
        .pop      (w_pop),
        .flush    (w_flush),
        .count    (w_fifo_count),
        .head     (w_fifo_head)
    );

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = w_head_vld;
    // Masked during reset so stale pre-reset contents never leak out.
    assign instr       = reset ? '0 : w_fifo_head[WORD_W-1:0];
    assign instr_pc    = reset ? '0 : w_fifo_head[PC_W+WORD_W-1:WORD_W];
    assign queue_count = reset ? '0 : w_fifo_count;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] r_perf_stall;
    logic [32:0] w_flush_sum;

    assign w_flush_sum = {1'b0, r_perf_flushed} + 33'(w_occ);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 1'b1;
            end
            if (redirect_valid) begin
                r_perf_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
            end
            if (w_head_vld && !id_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns 0xA0000000 | addr one cycle after a request.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  queue_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    fetch_unit #(.DEPTH(4), .PC_RESET(32'd0)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .id_ready       (id_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .queue_count    (queue_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle-latency instruction memory
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 | imem_addr;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        id_ready       = 1'b1;
        tick();
        tick();
        chk("rst_req",   imem_req,    0);
        chk("rst_vld",   instr_valid, 0);
        chk("rst_cnt",   queue_count, 0);
        chk("rst_instr", instr,       0);
        chk("rst_pc",    instr_pc,    0);

        // Release reset: cycle 0 issues PC 0
        reset = 1'b0;
        #1;
        chk("c0_req",  imem_req,  1);
        chk("c0_addr", imem_addr, 0);
        tick();
        chk("c1_addr", imem_addr, 1);
        chk("c1_vld",  instr_valid, 0);
        tick();
        // Cycle 2 onwards: one instruction per cycle
        for (int k = 0; k < 6; k++) begin
            chk("stream_vld",   instr_valid, 1);
            chk("stream_pc",    instr_pc,    k);
            chk("stream_instr", instr,       32'hA000_0000 | k);
            tick();
        end

        // Stall decode for 10 cycles: queue fills, requests stop
        id_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("full_cnt", queue_count, 4);
        chk("full_req", imem_req,    0);
        chk("full_vld", instr_valid, 1);
        chk("full_pc",  instr_pc,    6);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall10",  perf_stall,   10);
        chk("perf_fetched6", perf_fetched, 6);
`endif
        id_ready = 1'b1;
        #1;
        chk("full_req_hold", imem_req, 0);
        for (int k = 6; k < 12; k++) begin
            chk("drain_vld", instr_valid, 1);
            chk("drain_pc",  instr_pc,    k);
            if (k == 7) begin
                chk("resume_req",  imem_req,  1);
                chk("resume_addr", imem_addr, 10);
            end
            tick();
        end

        // Reset mid-stream
        reset = 1'b1;
        #1;
        chk("mrst_vld",   instr_valid, 0);
        chk("mrst_req",   imem_req,    0);
        chk("mrst_cnt",   queue_count, 0);
        chk("mrst_instr", instr,       0);
        chk("mrst_pc",    instr_pc,    0);
        tick();
        chk("mrst2_vld", instr_valid, 0);
        chk("mrst2_cnt", queue_count, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("mrst_perf_fetched", perf_fetched, 0);
`endif
        reset    = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("restart_req",  imem_req,  1);
        chk("restart_addr", imem_addr, 0);
        for (int k = 0; k < 4; k++) tick();
        // Cycle 4: three queued, PC 3 in flight
        chk("pre_redir_cnt", queue_count, 3);
        chk("pre_redir_req", imem_req,    0);

        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        #1;
        chk("redir_vld", instr_valid, 0);
        chk("redir_req", imem_req,    0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("post_redir_cnt",  queue_count, 0);
        chk("post_redir_req",  imem_req,    1);
        chk("post_redir_addr", imem_addr,   32'h40);
        chk("post_redir_vld",  instr_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flushed4", perf_flushed, 4);
        chk("perf_stall2",   perf_stall,   2);
`endif
        id_ready = 1'b1;
        tick();
        chk("refill_vld", instr_valid, 0);
        tick();
        chk("tgt_vld",   instr_valid, 1);
        chk("tgt_pc",    instr_pc,    32'h40);
        chk("tgt_instr", instr,       32'hA000_0040);
        tick();
        chk("tgt1_pc", instr_pc, 32'h41);

        // Redirect while head valid and decode ready: no pop, head discarded
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        #1;
        chk("rr_vld", instr_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rr_cnt",  queue_count, 0);
        chk("rr_addr", imem_addr,   32'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched1", perf_fetched, 1);
        chk("perf_flushed6", perf_flushed, 6);
        chk("perf_stall_hold", perf_stall, 2);
`endif
        tick();
        chk("rr_refill_vld", instr_valid, 0);
        tick();
        chk("rr_tgt_vld", instr_valid, 1);
        chk("rr_tgt_pc",  instr_pc,    32'h100);

        // PC wrap at 0xFFFFFFFF
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flushed8", perf_flushed, 8);
`endif
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        tick();
        chk("wrap_pc0",    instr_pc, 32'hFFFF_FFFF);
        chk("wrap_instr0", instr,    32'hFFFF_FFFF);
        tick();
        chk("wrap_pc1",    instr_pc, 32'h0);
        chk("wrap_instr1", instr,    32'hA000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
